// File: rtl/vpu_writeback_if.sv
// Row-collection interface: per-lane VPU results in, strided memory row writes out.
// master drives lanes and mem_wr_ready; slave (the writeback block) drives the write port.
interface vpu_writeback_if #(
    parameter int O_WIDTH       = 8,
    parameter int CHANNEL_WIDTH = 16,
    parameter int ADDR_WIDTH    = 16
);
    logic [CHANNEL_WIDTH-1:0]              vpu_out_valid;
    logic [CHANNEL_WIDTH-1:0][O_WIDTH-1:0] vpu_out;
    logic                                  mem_wr_valid;
    logic                                  mem_wr_ready;
    logic [ADDR_WIDTH-1:0]                 mem_wr_addr;
    logic [CHANNEL_WIDTH*O_WIDTH-1:0]      mem_wr_data;

    modport master (
        output vpu_out_valid, vpu_out, mem_wr_ready,
        input  mem_wr_valid, mem_wr_addr, mem_wr_data
    );

    modport slave (
        input  vpu_out_valid, vpu_out, mem_wr_ready,
        output mem_wr_valid, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/vpu_writeback.sv
// Collects VPU lane results into rows, queues them and writes them at base + n*stride; VPU_WRITEBACK_DESKEW_EN adds per-lane deskew.
// Row reaches the write port 2 cycles after its last lane at the earliest; stalls on mem_wr_ready, drops rows when the queue is full.
module vpu_writeback #(
    parameter int O_WIDTH       = 8,
    parameter int CHANNEL_WIDTH = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int ADDR_WIDTH    = 16,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] row_stride,
    input  logic [CNT_WIDTH-1:0]  row_count,
    vpu_writeback_if.slave        bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err_overflow,
    output logic                  err_lane,
    output logic                  err_stray
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int RW = CHANNEL_WIDTH * O_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    logic [CHANNEL_WIDTH-1:0]              w_al_vld;
    logic [CHANNEL_WIDTH-1:0][O_WIDTH-1:0] w_al_dat;

`ifdef VPU_WRITEBACK_DESKEW_EN
    // Lane k waits CHANNEL_WIDTH-1-k cycles so a diagonal wavefront lines up with the last lane.
    for (genvar k = 0; k < CHANNEL_WIDTH; k++) begin : g_lane
        localparam int D = CHANNEL_WIDTH - 1 - k;
        if (D == 0) begin : g_pass
            assign w_al_vld[k] = bus.vpu_out_valid[k];
            assign w_al_dat[k] = bus.vpu_out[k];
        end else begin : g_dly
            logic [D-1:0]              r_v;
            logic [D-1:0][O_WIDTH-1:0] r_d;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_v <= '0;
                    r_d <= '0;
                end else begin
                    r_v[0] <= bus.vpu_out_valid[k];
                    r_d[0] <= bus.vpu_out[k];
                    for (int j = 1; j < D; j++) begin
                        r_v[j] <= r_v[j-1];
                        r_d[j] <= r_d[j-1];
                    end
                end
            end
            assign w_al_vld[k] = r_v[D-1];
            assign w_al_dat[k] = r_d[D-1];
        end
    end
`else
    assign w_al_vld = bus.vpu_out_valid;
    assign w_al_dat = bus.vpu_out;
`endif

    state_t                            r_state;
    logic [CHANNEL_WIDTH-1:0]          r_in_vld;
    logic [RW-1:0]                     r_in_dat;
    logic [ADDR_WIDTH-1:0]             r_addr;
    logic [ADDR_WIDTH-1:0]             r_stride;
    logic [CNT_WIDTH-1:0]              r_row_count;
    logic [CNT_WIDTH-1:0]              r_push_cnt;
    logic [CNT_WIDTH-1:0]              r_wr_cnt;
    logic [FIFO_DEPTH-1:0][RW-1:0]     r_mem;
    logic [PW-1:0]                     r_wp;
    logic [PW-1:0]                     r_rp;
    logic [PW:0]                       r_fcnt;
    logic                              r_busy;
    logic                              r_done;
    logic                              r_err_ov;
    logic                              r_err_lane;
    logic                              r_err_stray;

    logic w_run, w_full, w_empty, w_complete, w_partial, w_room, w_pop, w_push;

    assign w_run      = (r_state == S_RUN);
    assign w_full     = (r_fcnt == (PW+1)'(FIFO_DEPTH));
    assign w_empty    = (r_fcnt == '0);
    assign w_complete = &r_in_vld;
    assign w_partial  = (|r_in_vld) && !w_complete;
    assign w_room     = (r_push_cnt < r_row_count);
    assign w_pop      = w_run && !w_empty && bus.mem_wr_ready;
    // A full queue still accepts when the head leaves in the same cycle.
    assign w_push     = w_complete && w_run && w_room && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_in_vld    <= '0;
            r_in_dat    <= '0;
            r_addr      <= '0;
            r_stride    <= '0;
            r_row_count <= '0;
            r_push_cnt  <= '0;
            r_wr_cnt    <= '0;
            r_mem       <= '0;
            r_wp        <= '0;
            r_rp        <= '0;
            r_fcnt      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_ov    <= 1'b0;
            r_err_lane  <= 1'b0;
            r_err_stray <= 1'b0;
        end else begin
            r_in_vld <= w_al_vld;
            r_in_dat <= w_al_dat;
            r_done   <= 1'b0;

            if (w_push) begin
                r_mem[r_wp] <= r_in_dat;
                r_wp        <= r_wp + 1'b1;
                r_push_cnt  <= r_push_cnt + 1'b1;
            end
            if (w_pop) begin
                r_rp     <= r_rp + 1'b1;
                r_addr   <= r_addr + r_stride;
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_fcnt <= r_fcnt + 1'b1;
            end else if (!w_push && w_pop) begin
                r_fcnt <= r_fcnt - 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr      <= base_addr;
                        r_stride    <= row_stride;
                        r_row_count <= row_count;
                        r_push_cnt  <= '0;
                        r_wr_cnt    <= '0;
                        r_err_ov    <= 1'b0;
                        r_err_lane  <= 1'b0;
                        r_err_stray <= 1'b0;
                        if (row_count == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (r_wr_cnt == r_row_count) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_wp    <= '0;
                    r_rp    <= '0;
                    r_fcnt  <= '0;
                end
            endcase

            // Error updates come last so an error in the start cycle is not lost to the clear.
            if (w_partial) begin
                r_err_lane <= 1'b1;
            end
            if (w_complete && (!w_run || !w_room)) begin
                r_err_stray <= 1'b1;
            end
            if (w_complete && w_run && w_room && w_full && !w_pop) begin
                r_err_ov <= 1'b1;
            end
        end
    end

    assign bus.mem_wr_valid = w_run && !w_empty;
    assign bus.mem_wr_addr  = r_addr;
    assign bus.mem_wr_data  = r_mem[r_rp];
    assign busy             = r_busy;
    assign done             = r_done;
    assign err_overflow     = r_err_ov;
    assign err_lane         = r_err_lane;
    assign err_stray        = r_err_stray;
endmodule
